// File: rtl/conv_output_stage.sv
// Output stage behind the pipelined adder tree: tag realignment, group accumulation,
// requantization, output FIFO and credit flow control. Optional macro RELU_EN clamps negative results to 0.
module conv_output_stage #(
  parameter int unsigned IN_W       = 28,
  parameter int unsigned OUT_W      = 14,
  parameter int unsigned SHIFT      = 7,
  parameter int unsigned ADDER_LAT  = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mac_valid,
  input  logic             mac_last,
  output logic             mac_ready,
  input  logic [IN_W-1:0]  sum_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + ADDER_LAT + 2);
  localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [ADDER_LAT-1:0] tag_v_q;
  logic [ADDER_LAT-1:0] tag_l_q;
  logic                 t_valid;
  logic                 t_last;

  logic [IN_W-1:0]      acc_q;
  logic [IN_W-1:0]      acc_d;
  logic [IN_W-1:0]      acc_sat;
  logic [IN_W:0]        add_ext;
  logic                 first_q;

  logic [IN_W:0]        rnd_sum;
  logic signed [IN_W:0] rq_shift;
  logic [OUT_W-1:0]     rq_d;

  logic [OUT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PW:0]          wr_ptr_q;
  logic [PW:0]          rd_ptr_q;
  logic [PW:0]          count;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 push_ok;
  logic                 overflow_q;

  logic [CW-1:0]        inflight;
  logic [CW-1:0]        committed;

  assign t_valid = tag_v_q[ADDER_LAT-1];
  assign t_last  = tag_l_q[ADDER_LAT-1];

  // The last flag is stored pre-qualified so the credit count can sum it directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v_q <= '0;
      tag_l_q <= '0;
    end else begin
      tag_v_q[0] <= mac_valid;
      tag_l_q[0] <= mac_valid & mac_last;
      for (int unsigned i = 1; i < ADDER_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
    end
  end

  always_comb begin
    add_ext = {acc_q[IN_W-1], acc_q} + {sum_in[IN_W-1], sum_in};
    if (add_ext[IN_W] != add_ext[IN_W-1])
      acc_sat = add_ext[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    else
      acc_sat = add_ext[IN_W-1:0];
    acc_d = first_q ? sum_in : acc_sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      first_q <= 1'b1;
    end else if (t_valid) begin
      acc_q   <= acc_d;
      first_q <= t_last;
    end
  end

  // Round half up at IN_W+1 bits, then clamp when the upper bits are not pure sign extension.
  always_comb begin
    rnd_sum  = {acc_d[IN_W-1], acc_d} + RND;
    rq_shift = $signed(rnd_sum) >>> SHIFT;
    if ((rq_shift[IN_W:OUT_W-1] == '0) || (rq_shift[IN_W:OUT_W-1] == '1))
      rq_d = rq_shift[OUT_W-1:0];
    else
      rq_d = rq_shift[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`ifdef RELU_EN
    if (rq_d[OUT_W-1])
      rq_d = '0;
`else
`endif
  end

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = t_valid & t_last;
  assign push_ok   = push & (~full | pop);
  assign out_data  = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[PW-1:0]] <= rq_d;
        wr_ptr_q                <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      if (push && !push_ok)
        overflow_q <= 1'b1;
    end
  end

  assign overflow_err = overflow_q;

  // Every last beat in flight already owns a FIFO slot; mac_ready grants one more.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ADDER_LAT; i++)
      inflight = inflight + CW'(tag_l_q[i]);
    committed = CW'(count) + inflight + CW'(mac_valid & mac_last);
  end

  assign mac_ready = (committed < CW'(FIFO_DEPTH));

endmodule
